// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution frame sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_I_F_BW = 8;
    localparam int DEF_IX     = 28;
    localparam int DEF_IY     = 28;
    localparam int DEF_KX     = 5;
    localparam int DEF_KY     = 5;

    // Number of valid (non-padded) kernel positions over the frame.
    function automatic int nwin(input int ix, input int iy, input int kx, input int ky);
        return (ix - kx + 1) * (iy - ky + 1);
    endfunction

    // Counter wide enough to hold max_val itself without wrapping.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    localparam int DEF_NPIX   = DEF_IX * DEF_IY;
    localparam int DEF_NWIN   = nwin(DEF_IX, DEF_IY, DEF_KX, DEF_KY);
    localparam int DEF_ADDR_W = $clog2(DEF_NPIX);
    localparam int DEF_WIN_W  = cnt_w(DEF_NWIN);

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Frame-RAM, line-buffer and controller signals of the frame sequencer.
interface conv_frame_sequencer_if #(
    parameter int I_F_BW = 8,
    parameter int ADDR_W = 10
);
    logic              i_start;
    logic              i_ds_ready;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [I_F_BW-1:0] i_rd_data;
    logic              o_pix_valid;
    logic [I_F_BW-1:0] o_pix;
    logic              i_win_valid;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        input  i_start, i_ds_ready, i_rd_data, i_win_valid,
        output o_rd_en, o_rd_addr, o_pix_valid, o_pix, o_busy, o_done, o_err
    );

    modport slave (
        output i_start, i_ds_ready, i_rd_data, i_win_valid,
        input  o_rd_en, o_rd_addr, o_pix_valid, o_pix, o_busy, o_done, o_err
    );
endinterface

// File: rtl/frame_addr_gen.sv
// Row-major frame address counter; holds at the last address instead of wrapping.
module frame_addr_gen #(
    parameter int DEPTH  = 784,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    assign last = (addr == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (en && !last) begin
            addr <= addr + 1'b1;
        end
    end
endmodule

// File: rtl/conv_frame_sequencer.sv
// Streams one IX*IY frame from a 1-cycle frame RAM to the 5x5 window stage and counts returned windows.
// FRAME_TIMEOUT_EN adds a DRAIN watchdog that raises o_err and forces the frame to finish.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int I_F_BW  = DEF_I_F_BW,
    parameter int IX      = DEF_IX,
    parameter int IY      = DEF_IY,
    parameter int KX      = DEF_KX,
    parameter int KY      = DEF_KY,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_frame_sequencer_if.master bus
);
    localparam int NPIX   = IX * IY;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int NW     = nwin(IX, IY, KX, KY);
    localparam int WIN_W  = cnt_w(NW);

    state_t            state;
    logic [WIN_W-1:0]  win_cnt;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              rd_last;
    logic              pix_valid;
    logic              start_ok;
    logic              win_hit;
    logic              win_full;
    logic              timeout_hit;

    assign start_ok = (state == IDLE) && bus.i_start;
    assign rd_en    = (state == FEED) && bus.i_ds_ready;
    assign win_hit  = bus.i_win_valid && ((state == FEED) || (state == DRAIN));
    assign win_full = (win_cnt == WIN_W'(NW));

    frame_addr_gen #(
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (rd_en),
        .addr  (addr),
        .last  (rd_last)
    );

    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_addr   = addr;
    assign bus.o_pix_valid = pix_valid;
    assign bus.o_pix       = bus.i_rd_data;
    assign bus.o_busy      = (state == FEED) || (state == DRAIN);
    assign bus.o_done      = (state == DONE);

`ifdef FRAME_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;
    logic            err_q;

    // wd counts cycles since the last window, the strobe cycle itself being 1.
    assign timeout_hit = (state == DRAIN) && !win_full && !bus.i_win_valid &&
                         (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else if (start_ok) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else if ((state == DRAIN) && !win_full) begin
            if (bus.i_win_valid) begin
                wd <= WD_W'(1);
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end

    assign bus.o_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign bus.o_err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            win_cnt   <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= rd_en;

            // A strobe coinciding with the last read is counted before DRAIN is entered.
            if (start_ok) begin
                win_cnt <= '0;
            end else if (win_hit && !win_full) begin
                win_cnt <= win_cnt + 1'b1;
            end

            case (state)
                IDLE:    if (bus.i_start) state <= FEED;
                FEED:    if (rd_en && rd_last) state <= DRAIN;
                DRAIN:   if (win_full || timeout_hit) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
